note_sequencer: RTL and testbench
=================================

# note_sequencer

Queues (note, duration) pairs and feeds them one at a time to the music player's `en`/`music_note`/`music_time` inputs, handshaking on its `music_busy` output. It sits between the UART command parser and the music player. It buffers notes so the parser never waits on playback, and it inserts a fixed silent gap between consecutive notes.

## Interface
- `CLK_HZ`, 12_000_000: clk_in frequency; derives the internal 1 ms tick.
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `ACK_MS`, 4: ms to wait for player_busy to rise after player_en asserts.
- `GAP_MS`, 20: silent ms between the end of one note and the issue of the next.

- `clk_in`, in, 1: system clock.
- `rst_n_in`, in, 1: reset, asynchronous, active-low.
- `wr_en`, in, 1: push {wr_note, wr_time} this cycle.
- `wr_note`, in, 5: tone index.
- `wr_time`, in, 8: duration in ms.
- `full`, out, 1: FIFO holds DEPTH entries.
- `level`, out, log2(DEPTH)+1: current entry count.
- `play`, in, 1: level; 1 = run, 0 = pause after the current note.
- `flush`, in, 1: pulse; discard all queued entries.
- `player_en`, out, 1: request to the player.
- `player_note`, out, 5: note presented to the player.
- `player_time`, out, 8: duration presented to the player.
- `player_busy`, in, 1: player busy flag, asynchronous to the tick; synchronise through 2 flops.
- `idle`, out, 1: state IDLE and FIFO empty.
- `ovf`, out, 1: sticky; a write was attempted while full.
- `ack_err`, out, 1: sticky; an issue timed out.

## Operation
- FIFO write:
  - wr_en && !full stores the entry and increments level.
  - wr_en && full drops the entry and sets ovf.
- FIFO pop occurs only on the ISSUE entry, in the same cycle the outputs load.
  - A simultaneous write and pop leaves level unchanged.
  - Pointers wrap modulo DEPTH.
- flush clears the pointers and level to 0 on the next edge. It has priority over a same-cycle wr_en, which is dropped without setting ovf. It does not affect the state machine or the note in progress.
- State machine (state/FSM):
  - IDLE: if play && level != 0, pop the head, load player_note/player_time, go ISSUE.
  - ISSUE: player_en=1. On synchronised busy=1 go WAIT_DONE. If ACK_MS ticks elapse first, set ack_err and go GAP.
  - WAIT_DONE: player_en=0. On synchronised busy=0 go GAP.
  - GAP: count GAP_MS ticks, then go IDLE.
- player_note/player_time hold their values from load until the next load. The player samples them on its own 1 ms clock, so they must stay stable throughout ISSUE and WAIT_DONE.
- play=0 is checked only in IDLE; a note in progress always completes.
- ovf and ack_err clear only on reset.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, tick counter 0.
  - Reset mid-note drops player_en immediately; the player is reset by the same rst_n_in.
- Tick: a free-running counter pulses once every CLK_HZ/1000 clk_in cycles. The ISSUE and GAP counters advance only on tick pulses.
  - Timeouts therefore have a ±1 ms quantisation.
  - Each counter resets to 0 on entry to its state.
- Write to full/level: visible 1 cycle after the wr_en edge.
- IDLE to ISSUE: 1 cycle after the condition holds. player_en rises on the same edge that loads the note.
- busy sampling: 2 clk_in synchroniser cycles plus 1 FSM cycle from a player_busy edge to the state change.
- Back-to-back notes: the next player_en rises GAP_MS ms + ≤1 tick + 4 cycles after player_busy falls.
- level max = DEPTH; its width is sized so DEPTH fits.

## Test plan
- Single note: reset, write (note 5, time 10), play=1, player model asserts busy 2 ms after en for 10 ms.
  - Required: player_en high until busy is seen, note=5, time=10.
  - Required: next state IDLE after 20 ms gap; idle=1.
- Burst of 3 writes in 3 consecutive cycles with play=0.
  - Required: level=3, no player_en.
  - Then play=1: notes are issued in write order, each separated by ≥20 ms of busy=0.
- Overflow, DEPTH=16: 17 writes.
  - Required: full=1, level=16, ovf=1.
  - Required: the 17th entry is never issued.
- Ack timeout: player model never asserts busy.
  - Required: player_en drops after 4 ms ±1, ack_err=1, the entry is consumed, and the next entry is issued after the gap.
- Flush mid-note: 4 entries queued, flush during WAIT_DONE.
  - Required: the current note completes, level=0, no further player_en.
- Reset mid-ISSUE: assert rst_n_in=0.
  - Required: player_en=0 and level=0 immediately; all outputs 0 after release.

Source files
------------

// File: rtl/note_sequencer.sv
// Buffers (note, duration) pairs in a FIFO and issues them one at a time to the
// music player, with an ack timeout and a fixed silent gap between notes.
module note_sequencer #(
  parameter int CLK_HZ = 12_000_000,
  parameter int DEPTH  = 16,
  parameter int ACK_MS = 4,
  parameter int GAP_MS = 20
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     wr_en,
  input  logic [4:0]               wr_note,
  input  logic [7:0]               wr_time,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     play,
  input  logic                     flush,
  output logic                     player_en,
  output logic [4:0]               player_note,
  output logic [7:0]               player_time,
  input  logic                     player_busy,
  output logic                     idle,
  output logic                     ovf,
  output logic                     ack_err
);

  localparam int AW       = $clog2(DEPTH);
  localparam int LW       = AW + 1;
  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MS_MAX   = (ACK_MS > GAP_MS) ? ACK_MS : GAP_MS;
  localparam int CW       = $clog2(MS_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

  state_t          state_r, state_nxt;
  logic [TW-1:0]   tick_cnt_r;
  logic            tick_s;
  logic            busy_meta_r, busy_sync_r;
  logic [CW-1:0]   ms_cnt_r, ms_cnt_nxt;
  logic            pop_s, push_s, ovf_set_s, ack_to_s, full_s;
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]   level_r, level_nxt;
  logic [12:0]     mem_r [DEPTH];

  assign tick_s    = (tick_cnt_r == TW'(TICK_DIV - 1));
  assign full_s    = (level_r == LW'(DEPTH));
  assign full      = full_s;
  assign level     = level_r;
  // flush wins over a same-cycle write, and the dropped write is not an overflow
  assign push_s    = wr_en && !full_s && !flush;
  assign ovf_set_s = wr_en && full_s && !flush;

  // Free-running 1 ms tick divider.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  // Two-flop synchroniser for the player's busy flag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_meta_r <= 1'b0;
      busy_sync_r <= 1'b0;
    end else begin
      busy_meta_r <= player_busy;
      busy_sync_r <= busy_meta_r;
    end
  end

  // Next-state logic; ms_cnt_r is shared by ISSUE and GAP and cleared on entry.
  always_comb begin
    state_nxt  = state_r;
    ms_cnt_nxt = ms_cnt_r;
    pop_s      = 1'b0;
    ack_to_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (play && (level_r != '0)) begin
          pop_s      = 1'b1;
          state_nxt  = ISSUE;
          ms_cnt_nxt = '0;
        end else begin
          state_nxt  = IDLE;
        end
      end
      ISSUE: begin
        if (busy_sync_r) begin
          state_nxt = WAIT_DONE;
        end else if (tick_s) begin
          if (ms_cnt_r == CW'(ACK_MS - 1)) begin
            ack_to_s   = 1'b1;
            state_nxt  = GAP;
            ms_cnt_nxt = '0;
          end else begin
            ms_cnt_nxt = ms_cnt_r + CW'(1);
          end
        end else begin
          state_nxt = ISSUE;
        end
      end
      WAIT_DONE: begin
        if (!busy_sync_r) begin
          state_nxt  = GAP;
          ms_cnt_nxt = '0;
        end else begin
          state_nxt  = WAIT_DONE;
        end
      end
      GAP: begin
        if (tick_s) begin
          if (ms_cnt_r == CW'(GAP_MS - 1)) begin
            state_nxt = IDLE;
          end else begin
            ms_cnt_nxt = ms_cnt_r + CW'(1);
          end
        end else begin
          state_nxt = GAP;
        end
      end
      default: begin
        state_nxt  = IDLE;
        ms_cnt_nxt = '0;
      end
    endcase
  end

  // FIFO occupancy after this cycle's flush, push and pop.
  always_comb begin
    level_nxt = level_r;
    if (flush) begin
      level_nxt = '0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   level_nxt = level_r + LW'(1);
        2'b01:   level_nxt = level_r - LW'(1);
        default: level_nxt = level_r;
      endcase
    end
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {wr_note, wr_time};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_nxt;
    end
  end

  // State register and registered player/status outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r     <= IDLE;
      ms_cnt_r    <= '0;
      player_en   <= 1'b0;
      player_note <= 5'd0;
      player_time <= 8'd0;
      idle        <= 1'b0;
      ovf         <= 1'b0;
      ack_err     <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      ms_cnt_r  <= ms_cnt_nxt;
      player_en <= (state_nxt == ISSUE);
      idle      <= (state_nxt == IDLE) && (level_nxt == '0);
      // note/time stay put from one load to the next so the player can sample late
      if (pop_s) begin
        {player_note, player_time} <= mem_r[rd_ptr_r];
      end
      if (ovf_set_s) begin
        ovf <= 1'b1;
      end
      if (ack_to_s) begin
        ack_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Randomised scoreboard bench for note_sequencer with a behavioural player model.
module tb_note_sequencer;

  localparam int CLK_HZ = 10_000;
  localparam int DEPTH  = 16;
  localparam int ACK_MS = 4;
  localparam int GAP_MS = 20;
  localparam int T      = CLK_HZ / 1000;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          wr_en, play, flush, player_busy;
  logic [4:0]    wr_note, player_note;
  logic [7:0]    wr_time, player_time;
  logic          full, player_en, idle, ovf, ack_err;
  logic [LW-1:0] level;

  note_sequencer #(.CLK_HZ(CLK_HZ), .DEPTH(DEPTH), .ACK_MS(ACK_MS), .GAP_MS(GAP_MS)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .wr_en(wr_en), .wr_note(wr_note),
    .wr_time(wr_time), .full(full), .level(level), .play(play), .flush(flush),
    .player_en(player_en), .player_note(player_note), .player_time(player_time),
    .player_busy(player_busy), .idle(idle), .ovf(ovf), .ack_err(ack_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { logic [4:0] note; logic [7:0] tm; } ent_t;
  ent_t exp_q[$];
  int   model_count = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   noack = 1'b0;
  int   ack_delay_ms = 2;
  int   pm_st = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in); #1;
    end
  endtask

  // Writes one entry; the reference FIFO only accepts it while below DEPTH.
  task automatic write_entry(input logic [4:0] n, input logic [7:0] t);
    ent_t e;
    wr_note = n; wr_time = t; wr_en = 1'b1;
    if (model_count < DEPTH) begin
      e.note = n; e.tm = t;
      exp_q.push_back(e);
      model_count++;
    end
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && idle && pm_st == 0 && !player_busy) && n < budget) begin
      tick(1);
      n++;
    end
    check("drain_in_time", (n < budget), 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_en"}, player_en, 0);
    check({tag, "_note"}, player_note, 0);
    check({tag, "_time"}, player_time, 0);
    check({tag, "_full"}, full, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_idle"}, idle, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_ack_err"}, ack_err, 0);
  endtask

  // Player model: optional ack delay, then busy for player_time ms.
  initial begin
    int pm_cnt, pm_dur;
    player_busy = 1'b0;
    forever begin
      @(posedge clk_in); #1;
      if (!rst_n_in) begin
        player_busy = 1'b0;
        pm_st = 0;
      end else begin
        case (pm_st)
          0: if (player_en) begin
               if (noack) pm_st = 3;
               else begin
                 pm_cnt = ack_delay_ms * T;
                 pm_dur = int'(player_time) * T;
                 pm_st  = 1;
               end
             end
          1: if (pm_cnt == 0) begin player_busy = 1'b1; pm_st = 2; end
             else pm_cnt--;
          2: if (pm_dur <= 1) begin player_busy = 1'b0; pm_st = 3; end
             else pm_dur--;
          3: if (!player_en) pm_st = 0;
          default: pm_st = 0;
        endcase
      end
    end
  end

  // Monitor: pops the scoreboard on each issue and checks handshake timing.
  initial begin
    logic en_q = 1'b0, busy_q = 1'b0;
    bit   gap_valid = 1'b0, busy_seen = 1'b0;
    int   cyc = 0, en_rise = 0, busy_rise = 0, gap_ref = 0;
    ent_t e;
    forever begin
      @(negedge clk_in);
      cyc++;
      if (!rst_n_in) begin
        en_q = 1'b0; busy_q = 1'b0; gap_valid = 1'b0;
      end else begin
        if (player_en && !en_q) begin
          if (exp_q.size() == 0) begin
            check("unexpected_issue", 1, 0);
          end else begin
            e = exp_q.pop_front();
            model_count--;
            check("issue_note", player_note, e.note);
            check("issue_time", player_time, e.tm);
          end
          if (gap_valid) check_range("gap_cycles", cyc - gap_ref, (GAP_MS - 1) * T, 1 << 30);
          en_rise = cyc;
          busy_seen = 1'b0;
        end
        if (player_busy && !busy_q && player_en) begin
          busy_seen = 1'b1;
          busy_rise = cyc;
        end
        if (!player_en && en_q) begin
          if (busy_seen) begin
            check_range("en_drop_after_busy", cyc - busy_rise, 2, 4);
          end else begin
            check_range("ack_timeout_cycles", cyc - en_rise, (ACK_MS - 1) * T, (ACK_MS + 1) * T);
            check("ack_err_on_timeout", ack_err, 1);
            gap_ref = cyc;
            gap_valid = 1'b1;
          end
        end
        if (!player_busy && busy_q) begin
          gap_ref = cyc;
          gap_valid = 1'b1;
        end
        en_q = player_en;
        busy_q = player_busy;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n_in = 1'b0; wr_en = 1'b0; wr_note = 5'd0; wr_time = 8'd0;
    play = 1'b0; flush = 1'b0;
    #23;
    check_outputs_zero("reset");
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    check_outputs_zero("release");
    tick(2);
    check("idle_after_reset", idle, 1);

    // single note
    write_entry(5'd5, 8'd10);
    check("single_level", level, 1);
    play = 1'b1;
    wait_drain(2000);
    check("single_level_after", level, 0);

    // burst of three while paused
    play = 1'b0;
    for (int i = 0; i < 3; i++) write_entry(5'($urandom_range(0, 31)), 8'($urandom_range(1, 8)));
    check("burst_level", level, 3);
    tick(50);
    check("burst_no_en", player_en, 0);
    play = 1'b1;
    wait_drain(3000);

    // overflow: DEPTH+1 writes, last one dropped
    play = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) write_entry(5'(i), 8'($urandom_range(1, 3)));
    check("ovf_full", full, 1);
    check("ovf_level", level, DEPTH);
    check("ovf_flag", ovf, 1);
    play = 1'b1;
    wait_drain(12000);
    check("ovf_sticky", ovf, 1);

    // ack timeout on two entries
    noack = 1'b1;
    write_entry(5'd9, 8'd4);
    write_entry(5'd10, 8'd4);
    wait_drain(2000);
    check("ack_err_sticky", ack_err, 1);
    noack = 1'b0;

    // randomised traffic with pauses
    for (int i = 0; i < 24; i++) begin
      tick($urandom_range(0, 150));
      play = ($urandom_range(0, 3) != 0);
      ack_delay_ms = $urandom_range(0, 2);
      if (model_count < DEPTH - 2) write_entry(5'($urandom), 8'($urandom_range(1, 8)));
    end
    play = 1'b1;
    wait_drain(30000);

    // flush during WAIT_DONE
    ack_delay_ms = 2;
    play = 1'b0;
    for (int i = 0; i < 4; i++) write_entry(5'(20 + i), 8'd6);
    play = 1'b1;
    n = 0;
    while (!player_busy && n < 500) begin tick(1); n++; end
    check("flush_busy_seen", (n < 500), 1);
    tick(10);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    exp_q.delete();
    model_count = 0;
    check("flush_level", level, 0);
    wait_drain(2000);
    tick(300);
    check("flush_idle", idle, 1);

    // reset while in ISSUE
    play = 1'b0;
    write_entry(5'd3, 8'd5);
    write_entry(5'd4, 8'd5);
    play = 1'b1;
    n = 0;
    while (!player_en && n < 100) begin tick(1); n++; end
    check("rst_issue_seen", (n < 100), 1);
    tick(5);
    #3;
    rst_n_in = 1'b0;
    #1;
    check("rst_async_en", player_en, 0);
    check("rst_async_level", level, 0);
    exp_q.delete();
    model_count = 0;
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    check_outputs_zero("rst_mid");
    tick(400);
    check("rst_no_reissue", player_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
